// File: rtl/glift_seq_multiplier_pkg.sv
// Shared types and GLIFT taint equations for the sequential multiplier.
// Each taint function says whether the gate output can be influenced by a tainted input.
package glift_seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic glift_and_t(input logic x, input logic y,
                                       input logic x_t, input logic y_t);
    return (x_t & y_t) | (x_t & y) | (y_t & x);
  endfunction

  function automatic logic glift_or_t(input logic x, input logic y,
                                      input logic x_t, input logic y_t);
    return (x_t & y_t) | (x_t & ~y) | (y_t & ~x);
  endfunction

  function automatic logic glift_xor_t(input logic x_t, input logic y_t);
    return x_t | y_t;
  endfunction

endpackage

// File: rtl/glift_seq_multiplier_if.sv
// Operand/result handshake bundle with per-bit taint shadows.
// The master drives operands and out_ready; the slave (multiplier) drives in_ready and the result.
interface glift_seq_multiplier_if #(
  parameter int WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     a_t;
  logic [WIDTH-1:0]     b_t;
  logic                 conservative;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic [2*WIDTH-1:0]   p_t;

  modport master (
    output in_valid, a, b, a_t, b_t, conservative, out_ready,
    input  in_ready, out_valid, p, p_t
  );

  modport slave (
    input  in_valid, a, b, a_t, b_t, conservative, out_ready,
    output in_ready, out_valid, p, p_t
  );

endinterface

// File: rtl/glift_seq_multiplier_add_row.sv
// Combinational ripple-carry row of GLIFT full adders, carry-in tied to untainted 0.
// Each half of the adder (xor, and, or gates) applies its own taint rule.
module glift_seq_multiplier_add_row
  import glift_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] x_t_i,
  input  logic [WIDTH-1:0] y_t_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] s_t_o,
  output logic             co_o,
  output logic             co_t_o
);

  logic [WIDTH:0]   c;
  logic [WIDTH:0]   c_t;
  logic [WIDTH-1:0] hx;
  logic [WIDTH-1:0] hx_t;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_t;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] h_t;

  always_comb begin
    c     = '0;
    c_t   = '0;
    hx    = '0;
    hx_t  = '0;
    g     = '0;
    g_t   = '0;
    h     = '0;
    h_t   = '0;
    s_o   = '0;
    s_t_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hx[i]     = x_i[i] ^ y_i[i];
      hx_t[i]   = glift_xor_t(x_t_i[i], y_t_i[i]);
      s_o[i]    = hx[i] ^ c[i];
      s_t_o[i]  = glift_xor_t(hx_t[i], c_t[i]);
      g[i]      = x_i[i] & y_i[i];
      g_t[i]    = glift_and_t(x_i[i], y_i[i], x_t_i[i], y_t_i[i]);
      h[i]      = c[i] & hx[i];
      h_t[i]    = glift_and_t(c[i], hx[i], c_t[i], hx_t[i]);
      c[i+1]    = g[i] | h[i];
      c_t[i+1]  = glift_or_t(g[i], h[i], g_t[i], h_t[i]);
    end
    co_o   = c[WIDTH];
    co_t_o = c_t[WIDTH];
  end

endmodule

// File: rtl/glift_seq_multiplier.sv
// Shift-add unsigned multiplier with GLIFT taint tracking; result WIDTH+1 edges after accept.
// Result is held in DONE until out_ready; no new operands are accepted while busy or holding.
module glift_seq_multiplier
  import glift_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  glift_seq_multiplier_if.slave    mul_if
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("glift_seq_multiplier: WIDTH must be at least 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, hi_t_q, hi_t_d;
  logic [WIDTH-1:0] lo_q, lo_d, lo_t_q, lo_t_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mcand_t_q, mcand_t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             any_t_q, any_t_d;
  logic [PW-1:0]    p_q, p_d, p_t_q, p_t_d;

  logic [WIDTH-1:0] pp, pp_t;
  logic [WIDTH-1:0] row_s, row_s_t;
  logic             row_co, row_co_t;

  // Partial product row: multiplicand gated by the current multiplier LSB.
  always_comb begin
    pp   = '0;
    pp_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp[i]   = mcand_q[i] & lo_q[0];
      pp_t[i] = glift_and_t(mcand_q[i], lo_q[0], mcand_t_q[i], lo_t_q[0]);
    end
  end

  glift_seq_multiplier_add_row #(
    .WIDTH (WIDTH)
  ) u_add_row (
    .x_i    (hi_q),
    .y_i    (pp),
    .x_t_i  (hi_t_q),
    .y_t_i  (pp_t),
    .s_o    (row_s),
    .s_t_o  (row_s_t),
    .co_o   (row_co),
    .co_t_o (row_co_t)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    hi_t_d    = hi_t_q;
    lo_d      = lo_q;
    lo_t_d    = lo_t_q;
    mcand_d   = mcand_q;
    mcand_t_d = mcand_t_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    any_t_d   = any_t_q;
    p_d       = p_q;
    p_t_d     = p_t_q;

    case (state_q)
      IDLE: begin
        if (mul_if.in_valid) begin
          hi_d      = '0;
          hi_t_d    = '0;
          lo_d      = mul_if.b;
          lo_t_d    = mul_if.b_t;
          mcand_d   = mul_if.a;
          mcand_t_d = mul_if.a_t;
          cnt_d     = '0;
          mode_d    = mul_if.conservative;
          any_t_d   = (|mul_if.a_t) | (|mul_if.b_t);
          state_d   = RUN;
        end
      end

      RUN: begin
        // {carry, sum, lo} shifted right by one; the consumed multiplier bit falls off lo.
        hi_d   = {row_co, row_s[WIDTH-1:1]};
        hi_t_d = {row_co_t, row_s_t[WIDTH-1:1]};
        lo_d   = {row_s[0], lo_q[WIDTH-1:1]};
        lo_t_d = {row_s_t[0], lo_t_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          p_d     = {hi_d, lo_d};
          p_t_d   = mode_q ? {PW{any_t_q}} : {hi_t_d, lo_t_d};
        end
      end

      DONE: begin
        if (mul_if.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      hi_t_q    <= '0;
      lo_q      <= '0;
      lo_t_q    <= '0;
      mcand_q   <= '0;
      mcand_t_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      any_t_q   <= 1'b0;
      p_q       <= '0;
      p_t_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      hi_t_q    <= hi_t_d;
      lo_q      <= lo_d;
      lo_t_q    <= lo_t_d;
      mcand_q   <= mcand_d;
      mcand_t_q <= mcand_t_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      any_t_q   <= any_t_d;
      p_q       <= p_d;
      p_t_q     <= p_t_d;
    end
  end

  assign mul_if.in_ready  = (state_q == IDLE);
  assign mul_if.out_valid = (state_q == DONE);
  assign mul_if.p         = p_q;
  assign mul_if.p_t       = p_t_q;

endmodule

// File: tb/tb_glift_seq_multiplier.sv
// Bench for glift_seq_multiplier: directed vectors plus random operands against a bit-level
// GLIFT model that accumulates full-width shifted partial-product rows into a 2*W accumulator.
module tb_glift_seq_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] p;
    logic [PW-1:0] pt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   acc_cyc;
  bit   ov_prev;
  bit   rnd_bp;
  exp_t exp_q[$];
  logic [PW-1:0] last_p;
  logic [PW-1:0] last_pt;

  glift_seq_multiplier_if #(.WIDTH(W)) bus ();

  glift_seq_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mul_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic t_and(input logic x, input logic y, input logic xt, input logic yt);
    return (xt & yt) | (xt & y) | (yt & x);
  endfunction

  function automatic logic t_or(input logic x, input logic y, input logic xt, input logic yt);
    return (xt & yt) | (xt & ~y) | (yt & ~x);
  endfunction

  // Product from plain arithmetic; precise taint from full-width row accumulation.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] at, input logic [W-1:0] bt,
                                 input logic m);
    exp_t e;
    logic [PW-1:0] acc, acc_t, row, row_t;
    logic c, ct, hx, hxt, g, gt, h, ht;
    acc   = '0;
    acc_t = '0;
    for (int i = 0; i < W; i++) begin
      row   = '0;
      row_t = '0;
      for (int j = 0; j < W; j++) begin
        row[i+j]   = a[j] & b[i];
        row_t[i+j] = t_and(a[j], b[i], at[j], bt[i]);
      end
      c  = 1'b0;
      ct = 1'b0;
      for (int k = 0; k < PW; k++) begin
        hx  = acc[k] ^ row[k];
        hxt = acc_t[k] | row_t[k];
        g   = acc[k] & row[k];
        gt  = t_and(acc[k], row[k], acc_t[k], row_t[k]);
        h   = c & hx;
        ht  = t_and(c, hx, ct, hxt);
        acc[k]   = hx ^ c;
        acc_t[k] = hxt | ct;
        c  = g | h;
        ct = t_or(g, h, gt, ht);
      end
    end
    e.p  = PW'(a) * PW'(b);
    e.pt = m ? {PW{(|at) | (|bt)}} : acc_t;
    return e;
  endfunction

  // Single compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && bus.in_ready) begin
        errors++;
        $display("FAIL handshake_excl: out_valid=1 and in_ready=1 (t=%0t)", $time);
      end
      if (bus.out_valid) begin
        if (!ov_prev) check("latency_edges", cyc - acc_cyc + 1, W + 1);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: p=0x%0h with nothing pending", bus.p);
        end else begin
          check("p", 32'(bus.p), 32'(exp_q[0].p));
          check("p_t", 32'(bus.p_t), 32'(exp_q[0].pt));
          if (bus.out_ready) begin
            last_p  = bus.p;
            last_pt = bus.p_t;
            void'(exp_q.pop_front());
          end
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_bp) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] at, input logic [W-1:0] bt, input logic m);
    bit acc;
    acc = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.a_t = at;
    bus.b_t = bt;
    bus.conservative = m;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: in_ready never seen, got 0 expected 1");
    end else begin
      exp_q.push_back(model(a, b, at, bt, m));
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL result_timeout: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] at, input logic [W-1:0] bt, input logic m);
    last_p  = 'x;
    last_pt = 'x;
    send(a, b, at, bt, m);
    wait_done();
  endtask

  initial begin
    logic [PW-1:0] p0, pt0;
    exp_t e;
    checks = 0;
    errors = 0;
    cyc = 0;
    acc_cyc = 0;
    rnd_bp = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.a_t = '0;
    bus.b_t = '0;
    bus.conservative = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_p", 32'(bus.p), 0);
    check("rst_p_t", 32'(bus.p_t), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-derived values pin the reference model.
    e = model(8'd3, 8'd5, 8'h00, 8'h00, 1'b0);
    check("model_3x5_p", 32'(e.p), 15);
    check("model_3x5_pt", 32'(e.pt), 0);
    e = model(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    check("model_ffxff_p", 32'(e.p), 32'hFE01);
    e = model(8'h5A, 8'h00, 8'h01, 8'h00, 1'b0);
    check("model_mask_pt", 32'(e.pt), 0);
    e = model(8'h5A, 8'h00, 8'h01, 8'h00, 1'b1);
    check("model_cons_pt", 32'(e.pt), 32'hFFFF);
    e = model(8'h01, 8'h33, 8'h00, 8'hFF, 1'b0);
    check("model_1x33_pt", 32'(e.pt), 32'h00FF);

    run_op(8'd3, 8'd5, 8'h00, 8'h00, 1'b0);
    check("dut_3x5_p", 32'(last_p), 15);
    check("dut_3x5_pt", 32'(last_pt), 0);
    run_op(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    check("dut_ffxff_p", 32'(last_p), 32'hFE01);
    check("dut_ffxff_pt", 32'(last_pt), 0);
    run_op(8'h5A, 8'h00, 8'h01, 8'h00, 1'b0);
    check("dut_mask_p", 32'(last_p), 0);
    check("dut_mask_pt", 32'(last_pt), 0);
    run_op(8'h5A, 8'h00, 8'h01, 8'h00, 1'b1);
    check("dut_cons_p", 32'(last_p), 0);
    check("dut_cons_pt", 32'(last_pt), 32'hFFFF);
    run_op(8'h00, 8'h33, 8'h00, 8'hFF, 1'b0);
    check("dut_0x33_p", 32'(last_p), 0);
    check("dut_0x33_pt", 32'(last_pt), 0);
    run_op(8'h01, 8'h33, 8'h00, 8'hFF, 1'b0);
    check("dut_1x33_p", 32'(last_p), 32'h33);
    check("dut_1x33_pt", 32'(last_pt), 32'h00FF);

    // Backpressure: result held, new operands ignored.
    bus.out_ready = 1'b0;
    last_p = 'x;
    send(8'hC3, 8'h09, 8'h10, 8'h00, 1'b0);
    for (int k = 0; k < 40 && !bus.out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_out_valid", 32'(bus.out_valid), 1);
    p0  = bus.p;
    pt0 = bus.p_t;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = k[0];
      bus.a = 8'hFF;
      bus.b = 8'hFF;
      @(posedge clk);
      #1;
      check("bp_p_stable", 32'(bus.p), 32'(p0));
      check("bp_pt_stable", 32'(bus.p_t), 32'(pt0));
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();
    check("bp_p", 32'(last_p), 32'h06DB);
    check("bp_idle_in_ready", 32'(bus.in_ready), 1);
    check("bp_idle_out_valid", 32'(bus.out_valid), 0);

    // Reset during the fourth RUN cycle aborts the operation.
    send(8'hAA, 8'h55, 8'h00, 8'h00, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_p", 32'(bus.p), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(8'd7, 8'd6, 8'h00, 8'h00, 1'b0);
    check("post_rst_p", 32'(last_p), 42);

    rnd_bp = 1'b1;
    for (int n = 0; n < 300; n++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom & $urandom & $urandom),
             W'($urandom & $urandom & $urandom), 1'($urandom_range(0, 1)));
    end
    rnd_bp = 1'b0;
    #1;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
